// File: rtl/kronecker_masked_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : kronecker_masked_pipe_if
// Description : Bundle of the advance, operand, randomness and result signals
//               of the masked Kronecker-delta pipeline. RND_W follows the
//               build option KRON_OUT_REFRESH_EN (adds SHARES bits).
// Revision    : 1.0 - initial release
// ============================================================================
interface kronecker_masked_pipe_if #(
    parameter int WIDTH = 8,
    parameter int ORDER = 2
);
    localparam int SHARES = ORDER + 1;
`ifdef KRON_OUT_REFRESH_EN
    localparam int RND_W  = (WIDTH - 1) * ORDER * (ORDER + 1) / 2 + SHARES;
`else
    localparam int RND_W  = (WIDTH - 1) * ORDER * (ORDER + 1) / 2;
`endif

    logic                      en;
    logic                      in_valid;
    logic [SHARES*WIDTH-1:0]   shared_inp;
    logic [RND_W-1:0]          rnd;
    logic                      out_valid;
    logic [SHARES-1:0]         out;

    // Operand source side
    modport master (
        output en, in_valid, shared_inp, rnd,
        input  out_valid, out
    );

    // Pipeline side
    modport slave (
        input  en, in_valid, shared_inp, rnd,
        output out_valid, out
    );
endinterface
`default_nettype wire

// File: rtl/kronecker_masked_pipe.sv
`default_nettype none
// ============================================================================
// Module      : kronecker_masked_pipe
// Description : Pipelined masked zero test. Share 0 is inverted so that the
//               operand becomes ~x, then a balanced tree of DOM-indep AND
//               gadgets (one register layer per level) ANDs all bits down to
//               one shared bit that is 1 iff x == 0. Global stall via en.
//               Optional macro KRON_OUT_REFRESH_EN adds a ring-refreshed
//               output register (one extra cycle of latency).
// Revision    : 1.0 - initial release
// ============================================================================
module kronecker_masked_pipe #(
    parameter int WIDTH = 8,
    parameter int ORDER = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    kronecker_masked_pipe_if.slave bus
);
    localparam int c_SHARES  = ORDER + 1;
    localparam int c_LEVELS  = $clog2(WIDTH);
    localparam int c_NPAIR   = ORDER * (ORDER + 1) / 2;
    localparam int c_NODES   = 2 * WIDTH - 1;
    localparam int c_GAD_RND = (WIDTH - 1) * c_NPAIR;
`ifdef KRON_OUT_REFRESH_EN
    localparam int c_VLD_DEPTH = c_LEVELS + 1;
`else
    localparam int c_VLD_DEPTH = c_LEVELS;
`endif

    // Index of the random bit shared by cross terms (i,j) and (j,i), i<j,
    // pairs enumerated lexicographically.
    function automatic int pair_idx(input int i, input int j);
        return i * c_SHARES - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // All shared operands of the tree as one flat vector: nodes 0..WIDTH-1
    // are the stage-0 bits, followed by each level's gadget outputs, LSB
    // pair first; the last node is the root.
    logic [c_NODES*c_SHARES-1:0] w_node;

    // Stage 0: invert share 0 only, bit k of every share is operand k.
    for (genvar k = 0; k < WIDTH; k++) begin : g_stage0
        for (genvar i = 0; i < c_SHARES; i++) begin : g_share
            if (i == 0) begin : g_inv
                assign w_node[k*c_SHARES + i] = ~bus.shared_inp[i*WIDTH + k];
            end else begin : g_pass
                assign w_node[k*c_SHARES + i] = bus.shared_inp[i*WIDTH + k];
            end
        end
    end

    for (genvar s = 1; s <= c_LEVELS; s++) begin : g_lvl
        localparam int c_N   = WIDTH >> s;
        localparam int c_SRC = 2 * WIDTH - 4 * c_N;
        localparam int c_DST = 2 * WIDTH - 2 * c_N;

        for (genvar j = 0; j < c_N; j++) begin : g_gad
            localparam int c_G = WIDTH - 2 * c_N + j;

            logic [c_SHARES-1:0]          w_a;
            logic [c_SHARES-1:0]          w_b;
            logic [c_SHARES-1:0]          w_c;
            logic [c_NPAIR-1:0]           w_r;
            logic [c_SHARES*c_SHARES-1:0] w_term;
            logic [c_SHARES*c_SHARES-1:0] r_term;

            assign w_a = w_node[(c_SRC + 2*j)     * c_SHARES +: c_SHARES];
            assign w_b = w_node[(c_SRC + 2*j + 1) * c_SHARES +: c_SHARES];
            assign w_r = bus.rnd[c_G * c_NPAIR +: c_NPAIR];

            // Inner products unmasked, cross products blinded by r_ij = r_ji.
            always_comb begin
                w_term = '0;
                for (int i = 0; i < c_SHARES; i++) begin
                    for (int m = 0; m < c_SHARES; m++) begin
                        if (i == m) begin
                            w_term[i*c_SHARES + m] = w_a[i] & w_b[m];
                        end else if (i < m) begin
                            w_term[i*c_SHARES + m] = (w_a[i] & w_b[m]) ^ w_r[pair_idx(i, m)];
                        end else begin
                            w_term[i*c_SHARES + m] = (w_a[i] & w_b[m]) ^ w_r[pair_idx(m, i)];
                        end
                    end
                end
            end

            // Every term is registered on its own before any recombination.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_term <= '0;
                end else if (bus.en) begin
                    r_term <= w_term;
                end
            end

            // Output share i is the XOR of the registered terms of row i.
            always_comb begin
                w_c = '0;
                for (int i = 0; i < c_SHARES; i++) begin
                    w_c[i] = ^r_term[i*c_SHARES +: c_SHARES];
                end
            end

            assign w_node[(c_DST + j) * c_SHARES +: c_SHARES] = w_c;
        end
    end

    logic [c_SHARES-1:0]    w_root;
    logic [c_VLD_DEPTH-1:0] r_vld;

    assign w_root = w_node[(c_NODES - 1) * c_SHARES +: c_SHARES];

    // Valid shift register, advancing in lock-step with the data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (bus.en) begin
            r_vld[0] <= bus.in_valid;
            for (int k = 1; k < c_VLD_DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

`ifdef KRON_OUT_REFRESH_EN
    logic [c_SHARES-1:0] w_rr;
    logic [c_SHARES-1:0] r_out;

    assign w_rr = bus.rnd[c_GAD_RND +: c_SHARES];

    // Ring refresh: share i picks up r_i and r_(i+1 mod SHARES).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (bus.en) begin
            r_out <= w_root ^ w_rr ^ {w_rr[0], w_rr[c_SHARES-1:1]};
        end
    end

    assign bus.out = r_out;
`else
    assign bus.out = w_root;
`endif

    assign bus.out_valid = r_vld[c_VLD_DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_kronecker_masked_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_kronecker_masked_pipe
// Description : Scoreboard bench for the masked zero-test pipeline. Each
//               accepted operand pushes its expected unshared result and the
//               enabled-cycle count at which it must appear; a monitor pops
//               and compares whenever out_valid is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kronecker_masked_pipe;
    localparam int WIDTH  = 8;
    localparam int ORDER  = 2;
    localparam int SHARES = ORDER + 1;
    localparam int NLEV   = $clog2(WIDTH);
`ifdef KRON_OUT_REFRESH_EN
    localparam int LAT    = NLEV + 1;
    localparam int RND_W  = (WIDTH - 1) * ORDER * (ORDER + 1) / 2 + SHARES;
`else
    localparam int LAT    = NLEV;
    localparam int RND_W  = (WIDTH - 1) * ORDER * (ORDER + 1) / 2;
`endif

    typedef struct {
        logic exp_bit;
        int   due;
        int   tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    kronecker_masked_pipe_if #(.WIDTH(WIDTH), .ORDER(ORDER)) bus ();

    kronecker_masked_pipe #(
        .WIDTH (WIDTH),
        .ORDER (ORDER)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   ecnt   = 0;
    int   ntag   = 0;
    logic adv    = 1'b0;
    exp_t m_e;
    logic m_got;

    // Count enabled edges; note whether the last edge moved the pipeline.
    always @(posedge clk) begin
        if (rst_n && bus.en) ecnt <= ecnt + 1;
        adv <= rst_n && bus.en;
    end

    // Monitor: one comparison per newly presented result slot.
    always @(negedge clk) begin
        if (rst_n && adv && bus.out_valid) begin
            m_got = ^bus.out;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_valid: out_valid=1 (zero=%0b) at cycle %0d, no operand pending",
                         m_got, ecnt);
            end else begin
                m_e = sb.pop_front();
                if (m_got !== m_e.exp_bit || ecnt != m_e.due)
                    $display("FAIL result#%0d: got zero=%0b at cycle %0d, want zero=%0b at cycle %0d",
                             m_e.tag, m_got, ecnt, m_e.exp_bit, m_e.due);
                else
                    passed++;
            end
        end else if (rst_n && adv && sb.size() > 0 && sb[0].due == ecnt) begin
            m_e = sb.pop_front();
            checks++;
            $display("FAIL missing#%0d: out_valid=0 at cycle %0d, want result zero=%0b",
                     m_e.tag, ecnt, m_e.exp_bit);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) $display("FAIL %s: got %0h, want %0h", name, got, want);
        else passed++;
    endtask

    // Drive one cycle from a negedge; model: result = (XOR of shares == 0).
    task automatic drive_raw(input logic v, input logic [SHARES*WIDTH-1:0] sh,
                             input logic e, input logic rzero);
        logic [WIDTH-1:0] val;
        val = '0;
        for (int i = 0; i < SHARES; i++) val ^= sh[i*WIDTH +: WIDTH];
        bus.shared_inp = sh;
        for (int k = 0; k < RND_W; k++) bus.rnd[k] = rzero ? 1'b0 : 1'($urandom_range(1, 0));
        bus.in_valid = v;
        bus.en       = e;
        if (v && e) begin
            sb.push_back('{(val == '0), ecnt + LAT, ntag});
            ntag++;
        end
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] val,
                        input logic e, input logic rzero);
        logic [SHARES*WIDTH-1:0] sh;
        logic [WIDTH-1:0]        acc;
        acc = val;
        for (int i = 1; i < SHARES; i++) begin
            sh[i*WIDTH +: WIDTH] = WIDTH'($urandom());
            acc ^= sh[i*WIDTH +: WIDTH];
        end
        sh[0 +: WIDTH] = acc;
        drive_raw(v, sh, e, rzero);
    endtask

    logic [WIDTH-1:0] nz_vals [4];
    logic [SHARES:0]  snap;

    initial begin
        logic [SHARES*WIDTH-1:0] zsh;
        logic [WIDTH-1:0]        acc;
        logic [WIDTH-1:0]        v;

        bus.en = 1'b0; bus.in_valid = 1'b0; bus.shared_inp = '0; bus.rnd = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", 32'(bus.out), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero operand with shares 0x5C, 0xA1, (0xFD for three shares).
        acc = '0;
        for (int i = 0; i < SHARES - 1; i++) begin
            zsh[i*WIDTH +: WIDTH] = (i == 0) ? WIDTH'(8'h5C) : (i == 1) ? WIDTH'(8'hA1) : WIDTH'($urandom());
            acc ^= zsh[i*WIDTH +: WIDTH];
        end
        zsh[(SHARES-1)*WIDTH +: WIDTH] = acc;
        drive_raw(1'b1, zsh, 1'b1, 1'b0);
        repeat (LAT + 1) step(1'b0, '0, 1'b1, 1'b0);

        // Non-zero operands, all-zero and random randomness.
        nz_vals[0] = WIDTH'(8'h47); nz_vals[1] = WIDTH'(8'h01);
        nz_vals[2] = WIDTH'(8'h80); nz_vals[3] = WIDTH'(8'hFF);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) step(1'b1, nz_vals[i], 1'b1, r == 0);
        repeat (LAT + 1) step(1'b0, '0, 1'b1, 1'b0);

        // Back-to-back stream, zeros at positions 1 and 6.
        for (int i = 0; i < 10; i++)
            step(1'b1, (i == 1 || i == 6) ? '0 : WIDTH'($urandom_range(255, 1)), 1'b1, 1'b0);
        repeat (LAT + 1) step(1'b0, '0, 1'b1, 1'b0);

        // Same stream with a 2-cycle stall in the middle; outputs must hold.
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                snap = {bus.out_valid, bus.out};
                for (int n = 0; n < 2; n++) begin
                    step(1'b1, WIDTH'($urandom()), 1'b0, 1'b0);
                    chk("stall_hold", 32'({bus.out_valid, bus.out}), 32'(snap));
                end
            end
            step(1'b1, (i == 1 || i == 6) ? '0 : WIDTH'($urandom_range(255, 1)), 1'b1, 1'b0);
        end
        repeat (LAT + 1) step(1'b0, '0, 1'b1, 1'b0);

        // Reset with three operands in flight.
        for (int i = 0; i < 3; i++) step(1'b1, (i == 0) ? '0 : WIDTH'($urandom()), 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(bus.out), 32'd0);
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        sb.delete();
        @(negedge clk);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (LAT + 3) step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with random stalls.
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(3, 0) == 0) ? '0 : WIDTH'($urandom());
            step($urandom_range(3, 0) != 0, v, $urandom_range(7, 0) != 0, $urandom_range(7, 0) == 0);
        end

        repeat (LAT + 4) step(1'b0, '0, 1'b1, 1'b0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/kronecker_masked_pipe.md
# kronecker_masked_pipe

Parametrised, pipelined masked Kronecker delta (zero test) for the multiplicative-masking AES datapath. It takes a Boolean-shared WIDTH-bit value with ORDER+1 shares and returns a Boolean-shared single bit, which is 1 iff the unshared input equals zero. The core is a balanced tree of DOM-indep AND gadgets with one register layer per tree level, a valid pipeline and a global stall. It replaces the fixed 8-bit, second-order zero test in the S-box zero-value handling path.

## Interface
- `WIDTH`, default 8: bits per share. Power of two, 2..32.
- `ORDER`, default 2: masking order d, 1..3. SHARES = ORDER+1.
- `RND_W`, derived: (WIDTH-1)·ORDER·(ORDER+1)/2 (21 for the defaults), plus SHARES when `KRON_OUT_REFRESH_EN` is defined.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: pipeline advance; 0 freezes all state.
- `in_valid` input 1: `shared_inp` carries an operand this cycle.
- `shared_inp` input SHARES·WIDTH: share i at bits [i·WIDTH +: WIDTH]; value = XOR of all shares.
- `rnd` input RND_W: fresh randomness, new every cycle.
- `out_valid` output 1: `out` carries a result.
- `out` output SHARES: share i at bit i; result = XOR of all bits.

## Operation
- Stage 0 is combinational. Invert share 0 only, so the shared value becomes ~x. Bit k of every share forms one shared operand.
- The tree has L = log2(WIDTH) levels. Level s (1..L) holds WIDTH/2^s DOM-indep AND gadgets. Each gadget pairs adjacent operands (2j, 2j+1) from the previous level.
- Each gadget computes, for shares a and b:
  - inner terms a_i·b_i, registered;
  - cross terms a_i·b_j ⊕ r_{ij} for i≠j, registered, with r_{ij} = r_{ji};
  - output share c_i = XOR of its registered terms, formed combinationally after the register.
  - Registered terms are never recombined before the register.
- Randomness usage: D(D+1)/2 bits per gadget.
  - Gadgets are numbered level 1 first, LSB operand pair first, continuing through level L.
  - Gadget g uses `rnd` bits [g·D(D+1)/2 +: D(D+1)/2].
  - Within a gadget, pairs (i,j) with i<j are taken in lexicographic order.
- Valid pipeline: an L-deep shift register (L+1 deep with refresh) carrying `in_valid`. It advances only when `en`=1.
- `en`=0: data registers, valid registers and outputs all hold. `rnd` is ignored.
- Reset, including mid-operation, clears every data and valid register. No partial result survives reset.

## Timing
- Reset values: `out`=0, `out_valid`=0, all internal registers 0.
- Latency: L cycles of `en`=1 (3 for WIDTH=8), L+1 with refresh.
  - An operand presented with `in_valid`=1 at edge t, under continuous `en`=1, appears with `out_valid`=1 after edge t+L−1.
- Throughput: one operand per enabled cycle. Back-to-back `in_valid` is allowed with no bubbles.
- `in_valid`=0 cycles produce `out_valid`=0 at the matching output slot. Data in that slot is don't-care but must be deterministic.
- Stall with `en`=0 for N cycles delays every in-flight result by exactly N cycles. Ordering and values are preserved.
- Simultaneous reset and `en`: reset wins.

## Configuration
- `KRON_OUT_REFRESH_EN`:
  - Defined: adds an output register stage with ring refresh. Out share i = c_i ⊕ r_i ⊕ r_{(i+1) mod SHARES}, using the top SHARES bits of `rnd`. Latency becomes L+1 and RND_W grows by SHARES.
  - Undefined: `out` is driven directly from the final gadget level, with latency L.

## Test plan
Defaults: WIDTH=8, ORDER=2, refresh off unless stated.
- Zero operand, random shares (e.g. shares 0x5C, 0xA1, 0xFD), random `rnd` → 3 cycles later `out_valid`=1 and XOR(`out`)=1.
- Non-zero operands 0x47, 0x01, 0x80, 0xFF → XOR(`out`)=0 each.
  - Repeat each operand with `rnd` all-zero and with `rnd` random; the unshared result must be identical.
- Stream of 10 back-to-back operands with zeros at positions 1 and 6 → `out_valid` high for 10 consecutive cycles. Unshared results are 1 only at positions 1 and 6, in order.
- Hold `en`=0 for 2 cycles in the middle of that stream → every result is delayed by exactly 2 cycles, values unchanged. `out` and `out_valid` are stable during the stall.
- Assert `rst_n`=0 while 3 operands are in flight → `out`=0 and `out_valid`=0 asynchronously. After release, no stale `out_valid` pulse appears.
- Parameter sweep (WIDTH, ORDER) = (4,1), (16,3), and defaults with `KRON_OUT_REFRESH_EN` → an exhaustive or random scoreboard matches, with latency 2, 4 and 4 cycles respectively.
